// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/load-store bus arbiter: FSM states, source select
// and the issue-priority helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arbState_t;

  typedef enum logic {
    ARB_SRC_INST = 1'b0,
    ARB_SRC_DATA = 1'b1
  } arbSrc_t;

  // Only meaningful when at least one port is eligible.
  function automatic arbSrc_t pickSrc(input logic dataFirst, input logic instElig,
                                      input logic dataElig);
    return (dataElig && (dataFirst || !instElig)) ? ARB_SRC_DATA : ARB_SRC_INST;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_resp_slot.sv
// Per-port response slot: done flag, captured read data and the abandon flag
// that discards the result of a redirected request.
module arb_resp_slot
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        abandonCond,
  input  logic        complete,
  input  logic        clearAbandon,
  input  logic        isRead,
  input  logic [31:0] busRdata,
  input  logic        pipe_stall,
  output logic        done,
  output logic [31:0] rdata
);

  logic abandon;
  logic discard;

  // A redirect seen in the completing cycle also discards the result.
  assign discard = abandon | (active & abandonCond);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      rdata   <= '0;
      abandon <= 1'b0;
    end else begin
      if (complete && !discard) begin
        done <= 1'b1;
        if (isRead) rdata <= busRdata;
      end else if (done && !pipe_stall) begin
        done <= 1'b0;
      end

      if (clearAbandon)              abandon <= 1'b0;
      else if (active && abandonCond) abandon <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch and load/store ports, one
// transaction at a time, holding results until the pipeline advances.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        i_stall,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  input  logic        pipe_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  arbState_t state;
  arbSrc_t   src;
  logic      instDone, dataDone;
  logic      instElig, dataElig;
  logic      busy, busDone;
  arbSrc_t   nextSrc;

  assign instElig = inst_req & ~instDone;
  assign dataElig = data_req & ~dataDone;
  assign i_stall  = inst_req & ~instDone;
  assign d_stall  = data_req & ~dataDone;
  assign busy     = (state != ARB_IDLE);
  assign busDone  = (state == ARB_DATA) & bus_data_ok;
  assign nextSrc  = pickSrc(DATA_FIRST, instElig, dataElig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      src       <= ARB_SRC_INST;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_wstrb <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (instElig || dataElig) begin
            src     <= nextSrc;
            bus_req <= 1'b1;
            state   <= ARB_ADDR;
            if (nextSrc == ARB_SRC_DATA) begin
              bus_wr    <= data_wr;
              bus_wstrb <= data_wr ? data_wstrb : 4'b0000;
              bus_addr  <= data_addr;
              bus_wdata <= data_wdata;
            end else begin
              bus_wr    <= 1'b0;
              bus_wstrb <= 4'b0000;
              bus_addr  <= inst_addr;
              bus_wdata <= '0;
            end
          end
        end
        ARB_ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (bus_data_ok) state <= ARB_IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

  arb_resp_slot uInstSlot (
    .clk          (clk),
    .rst          (rst),
    .active       (busy && src == ARB_SRC_INST),
    .abandonCond  (~inst_req | (inst_addr != bus_addr)),
    .complete     (busDone && src == ARB_SRC_INST),
    .clearAbandon (busDone),
    .isRead       (~bus_wr),
    .busRdata     (bus_rdata),
    .pipe_stall   (pipe_stall),
    .done         (instDone),
    .rdata        (inst_rdata)
  );

  arb_resp_slot uDataSlot (
    .clk          (clk),
    .rst          (rst),
    .active       (busy && src == ARB_SRC_DATA),
    .abandonCond  (~data_req | (data_addr != bus_addr)),
    .complete     (busDone && src == ARB_SRC_DATA),
    .clearAbandon (busDone),
    .isRead       (~bus_wr),
    .busRdata     (bus_rdata),
    .pipe_stall   (pipe_stall),
    .done         (dataDone),
    .rdata        (data_rdata)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed cycle-by-cycle bench for mem_bus_arbiter; the bench plays the bus
// bridge and pipeline, expected values are hand-computed per cycle.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        i_stall;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        pipe_stall = 1'b0;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .d_stall(d_stall),
    .pipe_stall(pipe_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Enter the next cycle: just past the rising edge, before new inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst inst_rdata", inst_rdata, 32'h0);
    chk("rst data_rdata", data_rdata, 32'h0);
    rst = 1'b0;

    // basic fetch, minimum latency
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC00000; #1;
    chk("f c0 i_stall", 32'(i_stall), 32'd1);
    chk("f c0 bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("f c1 bus_req", 32'(bus_req), 32'd1);
    chk("f c1 bus_addr", bus_addr, 32'hBFC00000);
    chk("f c1 bus_wr", 32'(bus_wr), 32'd0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24080001; #1;
    chk("f c2 bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_data_ok = 1'b0; bus_rdata = '0; #1;
    chk("f c3 inst_rdata", inst_rdata, 32'h24080001);
    chk("f c3 i_stall", 32'(i_stall), 32'd0);
    cyc(); inst_addr = 32'hBFC00004; #1;
    chk("f c4 i_stall (done cleared)", 32'(i_stall), 32'd1);
    chk("f c4 inst_rdata hold", inst_rdata, 32'h24080001);

    // next fetch, reset while in DATA
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("r c5 bus_addr", bus_addr, 32'hBFC00004);
    cyc(); bus_addr_ok = 1'b0; #1;
    rst = 1'b1; #1;
    chk("r bus_req", 32'(bus_req), 32'd0);
    chk("r i_stall", 32'(i_stall), 32'd1);
    chk("r inst_rdata", inst_rdata, 32'h0);
    chk("r bus_addr", bus_addr, 32'h0);
    cyc(); rst = 1'b0;
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("r reissue bus_req", 32'(bus_req), 32'd1);
    chk("r reissue addr", bus_addr, 32'hBFC00004);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11112222;
    cyc(); bus_data_ok = 1'b0; inst_req = 1'b0; #1;
    chk("r inst_rdata", inst_rdata, 32'h11112222);
    cyc();

    // simultaneous requests, data first
    cyc(); pipe_stall = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC00008;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80001000; #1;
    chk("s c0 i_stall", 32'(i_stall), 32'd1);
    chk("s c0 d_stall", 32'(d_stall), 32'd1);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("s c1 bus_addr", bus_addr, 32'h80001000);
    chk("s c1 bus_wstrb", 32'(bus_wstrb), 32'h0);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
    cyc(); bus_data_ok = 1'b0; #1;
    chk("s c3 data_rdata", data_rdata, 32'hCAFEF00D);
    chk("s c3 d_stall", 32'(d_stall), 32'd0);
    chk("s c3 i_stall", 32'(i_stall), 32'd1);
    chk("s c3 bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("s c4 bus_req", 32'(bus_req), 32'd1);
    chk("s c4 bus_addr", bus_addr, 32'hBFC00008);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C1D0001;
    cyc(); bus_data_ok = 1'b0; #1;
    chk("s c6 inst_rdata", inst_rdata, 32'h3C1D0001);
    chk("s c6 i_stall", 32'(i_stall), 32'd0);
    cyc(); pipe_stall = 1'b0; #1;
    chk("s c7 i_stall held", 32'(i_stall), 32'd0);
    chk("s c7 no reissue", 32'(bus_req), 32'd0);
    cyc(); inst_req = 1'b0; data_req = 1'b0; #1;
    chk("s c8 bus_req", 32'(bus_req), 32'd0);

    // store
    cyc(); pipe_stall = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b1100;
    data_addr = 32'h80001002; data_wdata = 32'hAABBCCDD;
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("w bus_wr", 32'(bus_wr), 32'd1);
    chk("w bus_wstrb", 32'(bus_wstrb), 32'hC);
    chk("w bus_wdata", bus_wdata, 32'hAABBCCDD);
    chk("w bus_addr", bus_addr, 32'h80001002);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    cyc(); bus_data_ok = 1'b0; pipe_stall = 1'b0; #1;
    chk("w data_rdata kept", data_rdata, 32'hCAFEF00D);
    chk("w d_stall", 32'(d_stall), 32'd0);
    cyc(); data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0;

    // fetch redirected while in DATA
    cyc(); pipe_stall = 1'b1; inst_req = 1'b1; inst_addr = 32'h80000010;
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("a c1 bus_addr", bus_addr, 32'h80000010);
    cyc(); bus_addr_ok = 1'b0; inst_addr = 32'hBFC00380;
    cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h0BADBAD0;
    cyc(); bus_data_ok = 1'b0; #1;
    chk("a c4 inst_rdata kept", inst_rdata, 32'h3C1D0001);
    chk("a c4 i_stall", 32'(i_stall), 32'd1);
    chk("a c4 bus_req", 32'(bus_req), 32'd0);
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("a c5 new bus_req", 32'(bus_req), 32'd1);
    chk("a c5 new bus_addr", bus_addr, 32'hBFC00380);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
    cyc(); bus_data_ok = 1'b0; pipe_stall = 1'b0; #1;
    chk("a c7 inst_rdata", inst_rdata, 32'h12345678);
    chk("a c7 i_stall", 32'(i_stall), 32'd0);
    cyc(); inst_req = 1'b0;

    // addr_ok withheld
    cyc(); pipe_stall = 1'b1; data_req = 1'b1; data_addr = 32'h80002000;
    inst_req = 1'b1; inst_addr = 32'hBFC00400;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("h bus_req", 32'(bus_req), 32'd1);
      chk("h bus_addr", bus_addr, 32'h80002000);
      chk("h bus_wr", 32'(bus_wr), 32'd0);
      chk("h d_stall", 32'(d_stall), 32'd1);
    end
    cyc(); bus_addr_ok = 1'b1; #1;
    chk("h c6 bus_addr", bus_addr, 32'h80002000);
    cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55AA55AA;
    cyc(); bus_data_ok = 1'b0; #1;
    chk("h data_rdata", data_rdata, 32'h55AA55AA);
    chk("h i_stall", 32'(i_stall), 32'd1);
    cyc(); #1;
    chk("h inst bus_addr", bus_addr, 32'hBFC00400);
    chk("h inst bus_req", 32'(bus_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
